pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Multi-cycle fetch/issue controller for the RV32I core.
- Owns the program counter and drives the instruction-memory request handshake.
- Presents each fetched instruction to decode/execute. Decode feeds `inst[31:7]` and the current PC to the immediate generator.
- Selects the next PC from the pre-added branch (Sb) and jump (Uj) targets that the immediate generator returns, or from a JALR target. Redirects to a trap vector on misaligned targets and counts retired instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- TRAP_PC, 32'h0000_0100, PC loaded on misaligned-target trap.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- halt  in  1  level; blocks new fetches while high
- imem_req  out  1  instruction fetch request
- imem_addr  out  32  fetch address (= pc)
- imem_valid  in  1  one-cycle pulse; imem_rdata valid
- imem_rdata  in  32  fetched instruction
- inst_valid  out  1  instruction held for execute
- inst  out  32  latched instruction
- pc  out  32  PC of current instruction
- ex_done  in  1  execute finished current instruction (pulse)
- br_taken  in  1  branch condition true (sampled with ex_done)
- br_target  in  32  Sb output (PC-relative, already added)
- jal  in  1  JAL decoded
- jal_target  in  32  Uj output (already added)
- jalr  in  1  JALR decoded
- jalr_target  in  32  rs1+I immediate; bit 0 cleared here
- trap  out  1  one-cycle pulse on misaligned target
- mepc  out  32  PC of the instruction that trapped
- instret  out  32  retired-instruction counter

Behaviour:
- States: RESET, FETCH, ISSUE, HALTED.
- Reset (async, rst_n=0): state RESET, pc=RESET_PC, imem_req=0, inst_valid=0, inst=0, trap=0, mepc=0, instret=0. All take effect immediately, including any request in flight; a later imem_valid is ignored until FETCH is re-entered.
- RESET -> FETCH on the first clk edge after rst_n rises, or RESET -> HALTED if halt=1.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - Request held high until imem_valid.
  - On imem_valid: inst<=imem_rdata, inst_valid<=1, state ISSUE.
  - Minimum fetch latency is 1 cycle (imem_valid on the cycle after req rises). imem_valid in any state other than FETCH is ignored.
- ISSUE:
  - imem_req=0; inst_valid=1; inst and pc stable until ex_done.
  - On ex_done, next PC priority: jalr (jalr_target & ~1) > jal (jal_target) > br_taken (br_target) > pc+4.
  - pc+4 wraps modulo 2^32.
  - Candidate with bits[1:0] != 00 is misaligned. Misaligned effects: trap=1 for exactly one cycle, mepc<=pc (the faulting instruction), pc<=TRAP_PC, and instret still increments.
  - Otherwise: pc<=candidate, instret<=instret+1 (wraps FFFF_FFFF -> 0).
  - On that edge: inst_valid<=0. State becomes HALTED if halt=1, else FETCH.
  - Total: one retirement per ex_done pulse; a second ex_done while not in ISSUE is ignored.
- HALTED: imem_req=0, inst_valid=0, pc held. Returns to FETCH on the first edge with halt=0.
- halt asserted during FETCH or ISSUE does not abort the current transaction; it takes effect at the end of the transaction.
- trap is registered; it is low in every cycle other than the one following the trapping ex_done edge.
- Simultaneous jal, jalr and br_taken resolve by priority only; no error is flagged.

Test Plan:
- Reset release, RESET_PC=0, imem_valid 2 cycles after req, rdata=32'h0000_0013, then ex_done with no control inputs -> imem_addr 0 then 4, inst=32'h13, instret=1.
- pc=32'h10, ex_done with br_taken=1, br_target=32'h0C -> next imem_addr=32'h0C; with jal=1, jal_target=32'h40 also high -> 32'h40 wins.
- jalr=1, jalr_target=32'h0000_0201 -> next PC 32'h200; jalr_target=32'h0000_0202 -> trap pulse 1 cycle, mepc=old pc, next imem_addr=32'h100.
- pc=32'hFFFF_FFFC, sequential retire -> pc=0; instret preset to FFFF_FFFF by prior retires (or forced) -> wraps to 0.
- halt=1 raised mid-FETCH -> fetch completes, ex_done retires, state HALTED with imem_req=0. halt=0 -> fetch resumes at the expected next PC.
- rst_n pulled low while imem_req=1 -> imem_req=0 immediately (same cycle, async); late imem_valid ignored; after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle fetch/issue controller for the RV32I core.
// Owns the program counter, runs the instruction-memory request handshake,
// holds each fetched instruction for decode/execute and picks the next PC
// from the JALR, JAL or branch target or from pc+4. A target that is not
// word-aligned redirects to TRAP_PC and records the faulting PC in mepc.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   halt                    level; blocks new fetches while high
//   imem_req / imem_addr    fetch request and address (= pc)
//   imem_valid / imem_rdata one-cycle response pulse and fetched word
//   inst_valid / inst / pc  instruction held for execute and its PC
//   ex_done                 execute finished the current instruction
//   br_taken / br_target    branch outcome and pre-added Sb target
//   jal / jal_target        JAL decoded and pre-added Uj target
//   jalr / jalr_target      JALR decoded and rs1+imm (bit 0 cleared here)
//   trap / mepc             misaligned-target pulse and faulting PC
//   instret                 retired-instruction counter
//
// state   | meaning
// --------+-------------------------------------------------------------
// RESET   | just out of reset; leaves on the first edge
// FETCH   | imem_req high at pc, waiting for imem_valid
// ISSUE   | instruction held for execute, waiting for ex_done
// HALTED  | halt seen at end of a transaction; no fetching

module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        halt,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_valid,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] pc,
   input  logic        ex_done,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        jal,
   input  logic [31:0] jal_target,
   input  logic        jalr,
   input  logic [31:0] jalr_target,
   output logic        trap,
   output logic [31:0] mepc,
   output logic [31:0] instret
);

   typedef enum logic [1:0] {
      ST_RESET  = 2'd0,
      ST_FETCH  = 2'd1,
      ST_ISSUE  = 2'd2,
      ST_HALTED = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] mepc_q, mepc_d;
   logic [31:0] instret_q, instret_d;
   logic        imem_req_q, imem_req_d;
   logic        inst_valid_q, inst_valid_d;
   logic        trap_q, trap_d;

   logic [31:0] pc_seq;
   logic [31:0] target;
   logic        misaligned;

   // Next-PC candidate; priority jalr > jal > branch > sequential.
   always_comb begin
      pc_seq = pc_q + 32'd4;
      if (jalr) begin
         target = {jalr_target[31:1], 1'b0};
      end else if (jal) begin
         target = jal_target;
      end else if (br_taken) begin
         target = br_target;
      end else begin
         target = pc_seq;
      end
      misaligned = (target[1:0] != 2'b00);
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      inst_d       = inst_q;
      mepc_d       = mepc_q;
      instret_d    = instret_q;
      imem_req_d   = imem_req_q;
      inst_valid_d = inst_valid_q;
      trap_d       = 1'b0;

      unique case (state_q)
         ST_RESET: begin
            if (halt) begin
               state_d    = ST_HALTED;
               imem_req_d = 1'b0;
            end else begin
               state_d    = ST_FETCH;
               imem_req_d = 1'b1;
            end
         end
         ST_FETCH: begin
            if (imem_valid) begin
               inst_d       = imem_rdata;
               inst_valid_d = 1'b1;
               imem_req_d   = 1'b0;
               state_d      = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (ex_done) begin
               inst_valid_d = 1'b0;
               instret_d    = instret_q + 32'd1;
               if (misaligned) begin
                  trap_d = 1'b1;
                  mepc_d = pc_q;
                  pc_d   = TRAP_PC;
               end else begin
                  pc_d = target;
               end
               // halt only takes effect once the instruction has retired
               if (halt) begin
                  state_d    = ST_HALTED;
                  imem_req_d = 1'b0;
               end else begin
                  state_d    = ST_FETCH;
                  imem_req_d = 1'b1;
               end
            end
         end
         ST_HALTED: begin
            inst_valid_d = 1'b0;
            imem_req_d   = 1'b0;
            if (!halt) begin
               state_d    = ST_FETCH;
               imem_req_d = 1'b1;
            end
         end
         default: begin
            state_d      = ST_RESET;
            imem_req_d   = 1'b0;
            inst_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_RESET;
         pc_q         <= RESET_PC;
         inst_q       <= 32'h0;
         mepc_q       <= 32'h0;
         instret_q    <= 32'h0;
         imem_req_q   <= 1'b0;
         inst_valid_q <= 1'b0;
         trap_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         inst_q       <= inst_d;
         mepc_q       <= mepc_d;
         instret_q    <= instret_d;
         imem_req_q   <= imem_req_d;
         inst_valid_q <= inst_valid_d;
         trap_q       <= trap_d;
      end
   end

   assign imem_req   = imem_req_q;
   assign imem_addr  = pc_q;
   assign inst_valid = inst_valid_q;
   assign inst       = inst_q;
   assign pc         = pc_q;
   assign trap       = trap_q;
   assign mepc       = mepc_q;
   assign instret    = instret_q;

endmodule
